// File: rtl/ray_jitter_gen.sv
// ray_jitter_gen
//   Produces one pixel's stratified (jittered) sub-pixel sample set. The pixel
//   is split into a 2^GRID_LOG2 x 2^GRID_LOG2 grid of cells. Each sample's
//   offset is the cell coordinate in the top bits, with PRNG bits filling the
//   remaining fraction. Samples are walked in row-major cell order.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rand_num   : 12-bit PRNG value, may change every cycle
//   start      : request one pixel's sample set (accepted only while idle)
//   busy       : high while a pixel is in progress
//   smp_valid  : sample presented (valid/ready handshake with smp_ready)
//   smp_ready  : consumer accepts the presented sample
//   smp_dx     : unsigned 0.12 x offset of the presented sample
//   smp_dy     : unsigned 0.12 y offset of the presented sample
//   smp_idx    : index of the presented sample, 0..SPP-1
//   smp_last   : smp_idx is the final sample of the pixel
//   done       : one-cycle pulse after the final sample is accepted
module ray_jitter_gen #(
    parameter int GRID_LOG2 = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            rand_num,
    input  logic                   start,
    output logic                   busy,
    output logic                   smp_valid,
    input  logic                   smp_ready,
    output logic [11:0]            smp_dx,
    output logic [11:0]            smp_dy,
    output logic [2*GRID_LOG2-1:0] smp_idx,
    output logic                   smp_last,
    output logic                   done
);

    localparam int IDX_W = 2 * GRID_LOG2;
    localparam int SPP   = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        DRAW_X,
        DRAW_Y,
        PRESENT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // The low PRNG bits are displaced by the cell coordinate and never used.
    logic rand_lsb_unused;
    assign rand_lsb_unused = ^rand_num[GRID_LOG2-1:0];

    assign smp_idx = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            smp_dx    <= '0;
            smp_dy    <= '0;
            smp_valid <= 1'b0;
            smp_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle is spent in IDLE, so a start arriving
                    // with the done pulse begins the next pixel immediately.
                    if (start) begin
                        state    <= DRAW_X;
                        idx      <= '0;
                        smp_last <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                DRAW_X: begin
                    // Column bits of the index select the x cell.
                    smp_dx <= {idx[GRID_LOG2-1:0], rand_num[11:GRID_LOG2]};
                    state  <= DRAW_Y;
                end
                DRAW_Y: begin
                    // Row bits of the index select the y cell.
                    smp_dy    <= {idx[IDX_W-1:GRID_LOG2], rand_num[11:GRID_LOG2]};
                    state     <= PRESENT;
                    smp_valid <= 1'b1;
                end
                PRESENT: begin
                    // Offsets and index are frozen until the consumer takes
                    // the sample; no PRNG bits are consumed while stalled.
                    if (smp_ready) begin
                        smp_valid <= 1'b0;
                        if (smp_last) begin
                            state    <= IDLE;
                            idx      <= '0;
                            smp_last <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= DRAW_X;
                            idx      <= idx + IDX_W'(1);
                            // Tracks idx so smp_last stays a plain register.
                            smp_last <= (idx == IDX_W'(SPP - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
